// File: rtl/ram_rd_stream.sv
// Streams one frame of samples out of the sample RAM with a DDS-style address step.
// Reads are credit-limited into a 4-entry output FIFO. Define RAM_RD_LOOP_EN for endless wrap with a stop port.
module ram_rd_stream #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 12,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] step,
`ifdef RAM_RD_LOOP_EN
    input  logic              stop,
`endif
    output logic              ram_rd_en,
    output logic [ADDR_W-1:0] ram_rd_addr,
    input  logic [DATA_W-1:0] ram_rd_data,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t            state;
    logic [ADDR_W-1:0] step_r;
`ifndef RAM_RD_LOOP_EN
    logic [ADDR_W-1:0] cnt;
`endif
    logic [2:0]        inflight;
    logic [2:0]        fifo_count;
    logic [RD_LAT-1:0] vld_sr;
    logic [DATA_W-1:0] fifo_mem [4];
    logic [1:0]        wr_ptr;
    logic [1:0]        rd_ptr;
    logic              push;
    logic              pop;
    logic [3:0]        occ_next;
    logic              credit_ok;
    logic              last_issue;
    logic              stop_req;

    assign push    = vld_sr[RD_LAT-1];
    assign m_valid = (fifo_count != 3'd0);
    assign m_data  = fifo_mem[rd_ptr];
    assign pop     = m_valid & m_ready;

    // Occupancy after this edge, counting the read on the bus now; a new read is
    // only allowed if its sample is guaranteed a FIFO slot.
    assign occ_next  = {1'b0, fifo_count} + {1'b0, inflight} + {3'b000, ram_rd_en} - {3'b000, pop};
    assign credit_ok = (occ_next < 4'd4);

`ifdef RAM_RD_LOOP_EN
    assign last_issue = 1'b0;
    assign stop_req   = stop;
`else
    assign last_issue = ram_rd_en && (cnt == '1);
    assign stop_req   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            step_r      <= '0;
`ifndef RAM_RD_LOOP_EN
            cnt         <= '0;
`endif
            ram_rd_en   <= 1'b0;
            ram_rd_addr <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            if (ram_rd_en) begin
                ram_rd_addr <= ram_rd_addr + step_r;
`ifndef RAM_RD_LOOP_EN
                cnt         <= cnt + ADDR_W'(1);
`endif
            end
            case (state)
                IDLE: begin
                    // The first read goes out right away; the FIFO is always empty here.
                    if (start) begin
                        state       <= READ;
                        busy        <= 1'b1;
                        ram_rd_addr <= start_addr;
                        step_r      <= (step == '0) ? ADDR_W'(1) : step;
`ifndef RAM_RD_LOOP_EN
                        cnt         <= '0;
`endif
                        ram_rd_en   <= 1'b1;
                    end
                end
                READ: begin
                    if (last_issue || stop_req) begin
                        state     <= DRAIN;
                        ram_rd_en <= 1'b0;
                    end else begin
                        ram_rd_en <= credit_ok;
                    end
                end
                DRAIN: begin
                    if ((inflight == 3'd0) && (fifo_count == 3'd0)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    ram_rd_en <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    // Return path: tag RAM data by delaying the read strobe, then queue it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_sr     <= '0;
            inflight   <= 3'd0;
            fifo_count <= 3'd0;
            wr_ptr     <= 2'd0;
            rd_ptr     <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            vld_sr[0] <= ram_rd_en;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_sr[i] <= vld_sr[i-1];
            end
            inflight   <= inflight + {2'b00, ram_rd_en} - {2'b00, push};
            fifo_count <= fifo_count + {2'b00, push} - {2'b00, pop};
            if (push) begin
                fifo_mem[wr_ptr] <= ram_rd_data;
                wr_ptr           <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_ram_rd_stream.sv
// Scoreboard bench for ram_rd_stream: a RAM model feeds the DUT, expected samples
// come from start_addr + k*step over a reference array.
module tb_ram_rd_stream;

    localparam int ADDR_W  = 10;
    localparam int DATA_W  = 12;
    localparam int RD_LAT  = 2;
    localparam int DEPTH   = 1 << ADDR_W;
    localparam int CREDITS = 4;
`ifdef RAM_RD_LOOP_EN
    localparam int STOP_AT = 2000;
`endif

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W-1:0] step;
`ifdef RAM_RD_LOOP_EN
    logic              stop;
`endif
    logic              ram_rd_en;
    logic [ADDR_W-1:0] ram_rd_addr;
    logic [DATA_W-1:0] ram_rd_data;
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;
    logic              busy;
    logic              done;

    logic [DATA_W-1:0] ram [DEPTH];
    logic [DATA_W-1:0] rd_pipe [RD_LAT];
    logic [DATA_W-1:0] exp_q [$];

    int n_cmp = 0;
    int n_fail = 0;
    int issued = 0;
    int popped = 0;
    int done_count = 0;
    int cyc = 0;
    int last_pop_cyc = 0;
    bit hold_valid = 1'b0;
    logic [DATA_W-1:0] held;
    bit ready_rnd = 1'b0;

    ram_rd_stream #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .RD_LAT(RD_LAT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .start_addr (start_addr),
        .step       (step),
`ifdef RAM_RD_LOOP_EN
        .stop       (stop),
`endif
        .ram_rd_en  (ram_rd_en),
        .ram_rd_addr(ram_rd_addr),
        .ram_rd_data(ram_rd_data),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .busy       (busy),
        .done       (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous RAM with RD_LAT cycles of latency; idle cycles return junk.
    always @(posedge clk) begin
        rd_pipe[0] <= ram_rd_en ? ram[ram_rd_addr] : DATA_W'($urandom);
        for (int i = 1; i < RD_LAT; i++) begin
            rd_pipe[i] <= rd_pipe[i-1];
        end
    end
    assign ram_rd_data = rd_pipe[RD_LAT-1];

    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_ready = ready_rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic check_output(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_le(input string name, input int act, input int limit);
        n_cmp++;
        if (act > limit) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected at most %0d (t=%0t)", name, act, limit, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every accepted sample, checks stall stability
    // and that outstanding reads never exceed the FIFO depth.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            issued     = 0;
            popped     = 0;
            hold_valid = 1'b0;
        end else begin
            cyc++;
            check_le("outstanding", issued - popped, CREDITS);
            if (ram_rd_en) issued++;
            if (hold_valid) begin
                check_output("stall_valid", int'(m_valid), 1);
                check_output("stall_data", int'(m_data), int'(held));
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("[TB] FAIL unexpected_sample: got %0d, expected no sample (t=%0t)", m_data, $time);
                end else begin
                    check_output("sample_data", int'(m_data), int'(exp_q.pop_front()));
                end
                popped++;
                last_pop_cyc = cyc;
            end
            hold_valid = m_valid && !m_ready;
            held       = m_data;
            if (done) done_count++;
        end
    end

    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_rd_en"}, int'(ram_rd_en), 0);
        check_output({tag, "_rd_addr"}, int'(ram_rd_addr), 0);
        check_output({tag, "_m_valid"}, int'(m_valid), 0);
        check_output({tag, "_m_data"}, int'(m_data), 0);
        check_output({tag, "_busy"}, int'(busy), 0);
        check_output({tag, "_done"}, int'(done), 0);
    endtask

    task automatic apply_stimulus(input logic [ADDR_W-1:0] addr, input logic [ADDR_W-1:0] stp,
                                  input bit mid_start, input int reset_at, input bit check_tput);
        int step_eff;
        int n_exp;
        int lat;
        int d0;
        int p0;
        int t_first;
        bit finished;
        bit did_start;
`ifdef RAM_RD_LOOP_EN
        bit did_stop = 1'b0;
        int at_stop = 0;
        n_exp = STOP_AT + 16;
`else
        n_exp = DEPTH;
`endif
        step_eff = (stp == '0) ? 1 : int'(stp);
        for (int k = 0; k < n_exp; k++) begin
            exp_q.push_back(ram[(int'(addr) + k * step_eff) % DEPTH]);
        end
        d0 = done_count;
        p0 = popped;
        @(posedge clk);
        #1;
        start      = 1'b1;
        start_addr = addr;
        step       = stp;
        @(posedge clk);
        #1;
        start      = 1'b0;
        start_addr = ADDR_W'($urandom);
        step       = ADDR_W'($urandom);
        check_output("busy_after_start", int'(busy), 1);
        lat = 1;
        while (!m_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_output("first_valid_latency", lat, 2 + RD_LAT);
        t_first   = cyc + 1;
        finished  = 1'b0;
        did_start = 1'b0;
        for (int t = 0; t < 20000 && !finished; t++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
`ifdef RAM_RD_LOOP_EN
            if (stop) at_stop = popped - p0;
            stop = 1'b0;
            if (!did_stop && (popped - p0) >= STOP_AT) begin
                stop     = 1'b1;
                did_stop = 1'b1;
            end
`endif
            if (done) begin
                finished = 1'b1;
            end else if (reset_at > 0 && (popped - p0) >= reset_at) begin
                rst_n = 1'b0;
                #1;
                check_reset_outputs("midreset");
                @(posedge clk);
                #1;
                rst_n = 1'b1;
                for (int i = 0; i < 8; i++) begin
                    @(posedge clk);
                    #1;
                    check_output("quiet_after_reset", int'(m_valid | ram_rd_en | busy), 0);
                end
                return;
            end else if (mid_start && !did_start && (popped - p0) >= 300) begin
                start      = 1'b1;
                start_addr = addr + ADDR_W'(5);
                step       = stp + ADDR_W'(1);
                did_start  = 1'b1;
            end
        end
        check_output("frame_finished", int'(finished), 1);
        check_output("busy_at_done", int'(busy), 0);
`ifdef RAM_RD_LOOP_EN
        check_le("samples_after_stop", (popped - p0) - at_stop, CREDITS);
        check_le("stop_point", STOP_AT, popped - p0);
        exp_q.delete();
`else
        check_output("frame_samples", popped - p0, DEPTH);
        check_output("leftover_expected", exp_q.size(), 0);
        if (check_tput) check_output("throughput_span", last_pop_cyc - t_first, DEPTH - 1);
`endif
        repeat (3) @(posedge clk);
        #1;
        check_output("done_pulses", done_count - d0, 1);
        check_output("idle_valid", int'(m_valid), 0);
    endtask

    initial begin
        logic [ADDR_W-1:0] a;
        logic [ADDR_W-1:0] s;
        rst_n      = 1'b0;
        start      = 1'b0;
        start_addr = '0;
        step       = '0;
`ifdef RAM_RD_LOOP_EN
        stop       = 1'b0;
`endif
        for (int i = 0; i < DEPTH; i++) ram[i] = DATA_W'(i);
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        $display("[TB] ramp, start 0 step 1");
        apply_stimulus(10'd0, 10'd1, 1'b0, 0, 1'b1);
        $display("[TB] wrap, start 1020 step 3");
        apply_stimulus(10'd1020, 10'd3, 1'b0, 0, 1'b1);
        $display("[TB] step 0 acts as 1");
        apply_stimulus(10'd7, 10'd0, 1'b0, 0, 1'b1);

        for (int i = 0; i < DEPTH; i++) ram[i] = DATA_W'($urandom);
        ready_rnd = 1'b1;
        for (int n = 0; n < 2; n++) begin
            a = ADDR_W'($urandom);
            s = ADDR_W'($urandom);
            $display("[TB] random ready, start %0d step %0d", a, s);
            apply_stimulus(a, s, 1'b0, 0, 1'b0);
        end

        a = ADDR_W'($urandom);
        s = ADDR_W'($urandom_range(1, 40));
        $display("[TB] reset at sample 500, then restart");
        apply_stimulus(a, s, 1'b0, 500, 1'b0);
        apply_stimulus(a, s, 1'b0, 0, 1'b0);

        a = ADDR_W'($urandom);
        s = ADDR_W'($urandom);
        $display("[TB] start pulsed while busy");
        apply_stimulus(a, s, 1'b1, 0, 1'b0);

        repeat (4) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
